// File: rtl/flit_eject_unit_if.sv
// Handshake bundle between the router ejection port, the ejection unit and
// the local host. The slave modport is the ejection unit itself; the master
// modport is the environment (router + host) that drives flits and ready.
interface flit_eject_unit_if #(
  parameter int unsigned FlitWidth = 82
);
  logic [FlitWidth-1:0] in_flit;
  logic [1:0]           credit_out;
  logic [FlitWidth-1:0] host_flit;
  logic                 host_valid;
  logic                 host_ready;

  modport master (
    output in_flit,
    output host_ready,
    input  credit_out,
    input  host_flit,
    input  host_valid
  );

  modport slave (
    input  in_flit,
    input  host_ready,
    output credit_out,
    output host_flit,
    output host_valid
  );
endinterface

// File: rtl/flit_eject_unit.sv
// Ejection endpoint: checks destination of incoming flits, buffers matching
// flits in a first-word-fall-through FIFO for the host, returns credits to
// the router for every consumed or discarded slot.
// Optional macro EJECT_STATS_EN enables the saturating misroute/drop counters;
// without it both counter outputs are tied to 0 and stat_clr is ignored.
module flit_eject_unit #(
  parameter int unsigned cur_x        = 0,
  parameter int unsigned cur_y        = 0,
  parameter int unsigned cur_z        = 0,
  parameter int unsigned PayloadWidth = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  flit_eject_unit_if.slave              ej,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          misroute_cnt,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  input  logic                          stat_clr
);

  localparam int unsigned FlitWidth   = PayloadWidth + 50;
  localparam int unsigned ValidBitPos = FlitWidth - 1;
  localparam int unsigned DstXPos     = FlitWidth - 10;
  localparam int unsigned DstYPos     = FlitWidth - 7;
  localparam int unsigned DstZPos     = FlitWidth - 4;
  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = AW + 1;

  localparam logic [2:0]    CurX  = 3'(cur_x);
  localparam logic [2:0]    CurY  = 3'(cur_y);
  localparam logic [2:0]    CurZ  = 3'(cur_z);
  localparam logic [CW-1:0] Depth = CW'(FIFO_DEPTH);

  logic [FlitWidth-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [1:0]           credit_q, credit_d;

  logic flit_valid, dst_match, full, pop, push, misroute, drop;

  // Classify the arriving flit and decide push/pop/discard for this edge
  always_comb begin
    flit_valid = ej.in_flit[ValidBitPos];
    dst_match  = (ej.in_flit[DstXPos +: 3] == CurX) &&
                 (ej.in_flit[DstYPos +: 3] == CurY) &&
                 (ej.in_flit[DstZPos +: 3] == CurZ);
    full       = (count_q == Depth);
    pop        = (count_q != '0) && ej.host_ready;
    // A pop frees a slot in the same edge, so a full FIFO still accepts
    push       = flit_valid && dst_match && (!full || pop);
    misroute   = flit_valid && !dst_match;
    drop       = flit_valid && dst_match && full && !pop;
    // Discarded flits never consumed a slot, so their credit goes straight back
    credit_d   = 2'(pop) + 2'(misroute || drop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // FIFO control state and credit return, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Flit storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ej.in_flit;
  end

  assign ej.host_valid = (count_q != '0);
  assign ej.host_flit  = ej.host_valid ? mem_q[rd_ptr_q] : '0;
  assign ej.credit_out = credit_q;
  assign fifo_count    = count_q;

`ifdef EJECT_STATS_EN
  logic [CNT_WIDTH-1:0] misroute_q, drop_q;

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misroute_q <= '0;
      drop_q     <= '0;
    end else if (stat_clr) begin
      misroute_q <= '0;
      drop_q     <= '0;
    end else begin
      if (misroute && (misroute_q != '1)) misroute_q <= misroute_q + CNT_WIDTH'(1);
      if (drop && (drop_q != '1))         drop_q     <= drop_q + CNT_WIDTH'(1);
    end
  end

  assign misroute_cnt = misroute_q;
  assign drop_cnt     = drop_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign misroute_cnt    = '0;
  assign drop_cnt        = '0;
`endif

endmodule

// File: tb/tb_flit_eject_unit.sv
// Bench for flit_eject_unit: a queue-based model of the ejection buffer is
// compared against the DUT every falling edge, and directed scenarios check
// hand-computed values at key points.
module tb_flit_eject_unit;

`ifdef EJECT_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       stat_clr;
  logic [3:0] fifo_count;
  logic [7:0] misroute_cnt;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  flit_eject_unit_if #(.FlitWidth(82)) bus ();

  flit_eject_unit #(
    .cur_x(0), .cur_y(0), .cur_z(1),
    .PayloadWidth(32), .FIFO_DEPTH(8), .CNT_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .ej           (bus),
    .fifo_count   (fifo_count),
    .misroute_cnt (misroute_cnt),
    .drop_cnt     (drop_cnt),
    .stat_clr     (stat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queue plus integer counters
  logic [81:0] mq[$];
  int          m_credit = 0;
  int          m_mis    = 0;
  int          m_drp    = 0;

  function automatic int stat_exp(input int v);
    return StatsOn ? v : 0;
  endfunction

  task automatic check(input string nm, input logic [81:0] got, input logic [81:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [81:0] mk(input bit v, input logic [2:0] x, input logic [2:0] y,
                                     input logic [2:0] z, input logic [31:0] p);
    logic [81:0] f;
    f        = '0;
    f[31:0]  = p;
    f[63:32] = ~p;
    f[74:72] = x;
    f[77:75] = y;
    f[80:78] = z;
    f[81]    = v;
    return f;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    m_credit = 0;
    m_mis    = 0;
    m_drp    = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit arr, ok, pp, disc;
      arr  = bus.in_flit[81];
      ok   = (bus.in_flit[74:72] == 3'd0) && (bus.in_flit[77:75] == 3'd0) &&
             (bus.in_flit[80:78] == 3'd1);
      pp   = (mq.size() > 0) && bus.host_ready;
      disc = 1'b0;
      if (pp) void'(mq.pop_front());
      if (arr && !ok) disc = 1'b1;
      else if (arr && ok) begin
        if (mq.size() < 8) mq.push_back(bus.in_flit);
        else disc = 1'b1;
      end
      m_credit = int'(pp) + int'(disc);
      if (stat_clr) begin
        m_mis = 0;
        m_drp = 0;
      end else begin
        if (arr && !ok && m_mis < 255) m_mis++;
        if (arr && ok && disc && m_drp < 255) m_drp++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("cmp_valid", 82'(bus.host_valid), 82'(mq.size() != 0));
    check("cmp_flit", bus.host_flit, (mq.size() != 0) ? mq[0] : 82'd0);
    check("cmp_count", 82'(fifo_count), 82'(mq.size()));
    check("cmp_credit", 82'(bus.credit_out), 82'(m_credit));
    check("cmp_mis", 82'(misroute_cnt), 82'(stat_exp(m_mis)));
    check("cmp_drop", 82'(drop_cnt), 82'(stat_exp(m_drp)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    stat_clr       = 1'b0;
    bus.in_flit    = '0;
    bus.host_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 82'(bus.host_valid), 82'd0);
    check("rst_flit", bus.host_flit, 82'd0);
    check("rst_count", 82'(fifo_count), 82'd0);
    check("rst_credit", 82'(bus.credit_out), 82'd0);
    check("rst_mis", 82'(misroute_cnt), 82'd0);
    rst_n = 1'b1;
    tick();

    // Single flit, immediate pop
    bus.host_ready = 1'b1;
    bus.in_flit    = mk(1, 0, 0, 1, 32'hDEADBEEF);
    tick();
    bus.in_flit = '0;
    check("t1_valid", 82'(bus.host_valid), 82'd1);
    check("t1_payload", 82'(bus.host_flit[31:0]), 82'hDEADBEEF);
    tick();
    check("t1_credit", 82'(bus.credit_out), 82'd1);
    check("t1_count", 82'(fifo_count), 82'd0);
    tick();

    // Fill to full, drop the ninth, then drain in order
    bus.host_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.in_flit = mk(1, 0, 0, 1, 32'(i));
      tick();
    end
    check("t2_count", 82'(fifo_count), 82'd8);
    check("t2_valid", 82'(bus.host_valid), 82'd1);
    check("t2_head", 82'(bus.host_flit[31:0]), 82'd1);
    bus.in_flit = mk(1, 0, 0, 1, 32'd9);
    tick();
    check("t2_drop_credit", 82'(bus.credit_out), 82'd1);
    check("t2_drop_cnt", 82'(drop_cnt), 82'(stat_exp(1)));
    bus.in_flit    = '0;
    bus.host_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t2_order", 82'(bus.host_flit[31:0]), 82'(i));
      tick();
      check("t2_pop_credit", 82'(bus.credit_out), 82'd1);
    end
    check("t2_empty", 82'(fifo_count), 82'd0);

    // Misrouted flit
    bus.in_flit = mk(1, 1, 0, 0, 32'h55);
    tick();
    bus.in_flit = '0;
    check("t3_valid", 82'(bus.host_valid), 82'd0);
    check("t3_mis", 82'(misroute_cnt), 82'(stat_exp(1)));
    check("t3_credit", 82'(bus.credit_out), 82'd1);
    tick();

    // Full + pop + push, then pop + misroute
    bus.host_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_flit = mk(1, 0, 0, 1, 32'(16 + i));
      tick();
    end
    bus.host_ready = 1'b1;
    bus.in_flit    = mk(1, 0, 0, 1, 32'd100);
    tick();
    check("t4_count", 82'(fifo_count), 82'd8);
    check("t4_credit", 82'(bus.credit_out), 82'd1);
    check("t4_drop", 82'(drop_cnt), 82'(stat_exp(1)));
    bus.in_flit = mk(1, 0, 1, 1, 32'd101);
    tick();
    check("t4_credit2", 82'(bus.credit_out), 82'd2);
    check("t4_count7", 82'(fifo_count), 82'd7);
    bus.in_flit = '0;
    repeat (8) tick();
    check("t4_drained", 82'(fifo_count), 82'd0);

    // Counter saturation and clear priority
    bus.host_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.in_flit = mk(1, 3'(i % 7 + 1), 0, 0, 32'(i));
      tick();
    end
    check("t5_sat", 82'(misroute_cnt), 82'(stat_exp(255)));
    stat_clr    = 1'b1;
    bus.in_flit = mk(1, 2, 2, 2, 32'd7);
    tick();
    stat_clr    = 1'b0;
    bus.in_flit = '0;
    check("t5_clr", 82'(misroute_cnt), 82'd0);
    tick();

    // Asynchronous reset with flits buffered and a credit pending
    for (int i = 0; i < 5; i++) begin
      bus.in_flit = mk(1, 0, 0, 1, 32'(200 + i));
      tick();
    end
    bus.in_flit = mk(1, 4, 0, 0, 32'd300);
    tick();
    bus.in_flit = '0;
    check("t6_pre_count", 82'(fifo_count), 82'd5);
    check("t6_pre_credit", 82'(bus.credit_out), 82'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 82'(bus.host_valid), 82'd0);
    check("t6_count", 82'(fifo_count), 82'd0);
    check("t6_credit", 82'(bus.credit_out), 82'd0);
    check("t6_flit", bus.host_flit, 82'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flit_eject_unit.md
Name: flit_eject_unit

Overview:
- Ejection-side endpoint of a node: the receiving end of the flit stream a router delivers to its local host, i.e. the reverse of the inject path.
- Accepts 82-bit flits from the router's ejection output and checks that the destination coordinates match this node.
- Buffers accepted flits in a first-word-fall-through FIFO and presents them to the host with a valid/ready handshake.
- Returns credits to the router's ejection credit counter; keeps saturating misroute/drop statistics.

Parameters:
cur_x, 0, node X coordinate (3 bits significant)
cur_y, 0, node Y coordinate
cur_z, 0, node Z coordinate
PayloadWidth, 32, payload width; flit layout derives from it (FlitWidth = PayloadWidth+50 = 82 at default)
FIFO_DEPTH, 8, ejection buffer entries, power of two, >= 2
CNT_WIDTH, 8, width of statistics counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_flit  in  FlitWidth  flit from router ejection port; flit valid = bit ValidBitPos (81); dst X/Y/Z at bits 72/75/78, 3 bits each
credit_out  out  2  number of buffer slots returned to router this cycle (0..2)
host_flit  out  FlitWidth  head-of-FIFO flit
host_valid  out  1  FIFO non-empty
host_ready  in  1  host accepts head flit when host_valid=1
fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy
misroute_cnt  out  CNT_WIDTH  flits with dst != (cur_x,cur_y,cur_z), saturating
drop_cnt  out  CNT_WIDTH  flits arriving with FIFO full and no pop, saturating
stat_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (rst=0, async): FIFO empty, rd/wr pointers 0, host_valid=0, host_flit=0, credit_out=0, fifo_count=0, counters 0.
- Arrival: in_flit[81]=1 marks a flit; it is sampled on the rising clk edge.
- Classification, same cycle as arrival:
  - MATCH: dst == cur coordinates.
  - MISROUTE: dst differs; flit discarded, misroute_cnt+1.
  - DROP: MATCH, FIFO full, no pop this cycle; flit discarded, drop_cnt+1.
- Push: MATCH and (not full, or pop in same cycle). Full + pop + push succeeds; occupancy stays FIFO_DEPTH.
- Pop: host_valid & host_ready. FWFT: next entry visible on host_flit the cycle after the pop edge.
- Latency: a flit sampled at edge N into an empty FIFO gives host_valid=1 and host_flit=flit after edge N (registered output).
- host_flit is held stable while host_valid=1 and host_ready=0; it is 0 when empty.
- Credits, registered one cycle after the event:
  - +1 for each pop.
  - +1 for each MISROUTE or DROP flit (slot never consumed).
  - Pop + discard in the same cycle gives credit_out=2.
  - Router initialises its counter to FIFO_DEPTH.
- Counters: saturate at all-ones. stat_clr has priority over an increment in the same cycle (result 0).
- Pointers wrap modulo FIFO_DEPTH; full is derived from fifo_count == FIFO_DEPTH.
- Reset mid-operation: all buffered flits are lost and no credits are returned; the router is reset by the same rst.

Optional Feature:
- Macro EJECT_STATS_EN.
- Defined: misroute_cnt/drop_cnt and stat_clr logic are implemented as above.
- Undefined: counter registers are omitted and both outputs are tied to 0; stat_clr is ignored. Discard and credit behaviour is unchanged.

Test Plan:
- Reset, cur=(0,0,1), inject one flit with bit81=1, bit78=1, payload 0xDEADBEEF, host_ready=1 -> host_valid=1 one cycle later with payload 0xDEADBEEF; popped that cycle; credit_out=1 the following cycle; fifo_count returns to 0.
- host_ready=0, inject 8 matching flits (payload 1..8) -> fifo_count=8, host_valid=1, host_flit payload=1. A 9th flit -> drop_cnt=1, credit_out=1. Then host_ready=1 -> payloads 1..8 drain in order, eight credit_out=1 pulses.
- Flit with dst=(1,0,0) -> not enqueued, host_valid stays 0, misroute_cnt=1, credit_out=1 next cycle.
- FIFO full with host_ready=1 and a matching flit arriving in the same cycle -> push accepted, fifo_count stays 8, drop_cnt unchanged, credit_out=1. Pop plus a misrouted arrival in one cycle -> credit_out=2.
- Drive 300 misrouted flits -> misroute_cnt saturates at 255. stat_clr asserted coincident with a misroute -> counter reads 0.
- Assert rst=0 asynchronously with 5 flits buffered -> host_valid, fifo_count, credit_out drop to 0 immediately, without waiting for a clock edge.
